// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialization sequencer: drives the JEDEC init command train, then raises init_done.
// Optional OCD default/exit steps are built when DDR2_OCD_CAL_EN is defined.
module ddr2_init_seq #(
  parameter int unsigned T_CKE_LOW      = 100,
  parameter int unsigned T_XPR          = 20,
  parameter int unsigned T_RP           = 5,
  parameter int unsigned T_MRD          = 2,
  parameter int unsigned T_RFC          = 26,
  parameter int unsigned T_DLLK         = 200,
  parameter int unsigned CAS_LATENCY    = 5,
  parameter int unsigned WRITE_RECOVERY = 6,
  parameter int unsigned ADDR_W         = 14
) (
  input  logic              clk,
  input  logic              rst,
  output logic              cke,
  output logic              cs_n,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [1:0]        ba,
  output logic [ADDR_W-1:0] addr,
  output logic              odt,
  output logic              init_done,
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    S_CKE_LOW   = 4'd0,
    S_XPR       = 4'd1,
    S_PREA0     = 4'd2,
    S_EMR2      = 4'd3,
    S_EMR3      = 4'd4,
    S_EMR1      = 4'd5,
    S_MR_DLLRST = 4'd6,
    S_PREA1     = 4'd7,
    S_REF0      = 4'd8,
    S_REF1      = 4'd9,
    S_MR        = 4'd10,
`ifdef DDR2_OCD_CAL_EN
    S_OCD_DEF   = 4'd11,
    S_OCD_EXIT  = 4'd12,
`endif
    S_DLLK      = 4'd13,
    S_DONE      = 4'd14
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  function automatic logic [15:0] clamp_cyc(input int unsigned v);
    logic [15:0] r;
    if (v == 32'd0) begin
      r = 16'd1;
    end else if (v > 32'd65535) begin
      r = 16'hFFFF;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  localparam logic [15:0] CKE_LOW_C = clamp_cyc(T_CKE_LOW);
  localparam logic [15:0] XPR_C     = clamp_cyc(T_XPR);
  localparam logic [15:0] RP_C      = clamp_cyc(T_RP);
  localparam logic [15:0] MRD_C     = clamp_cyc(T_MRD);
  localparam logic [15:0] RFC_C     = clamp_cyc(T_RFC);
  localparam logic [15:0] DLLK_C    = clamp_cyc(T_DLLK);
  localparam logic [2:0]  CL_F      = 3'(CAS_LATENCY);
  localparam logic [2:0]  WR_F      = (WRITE_RECOVERY == 32'd0) ? 3'd0 : 3'(WRITE_RECOVERY - 32'd1);

  // Mode register: WR-1, DLL reset, CL, sequential burst, BL4
  function automatic logic [ADDR_W-1:0] mr_word(input logic dll_rst);
    logic [ADDR_W-1:0] w;
    w       = '0;
    w[11:9] = WR_F;
    w[8]    = dll_rst;
    w[7]    = 1'b0;
    w[6:4]  = CL_F;
    w[3]    = 1'b0;
    w[2:0]  = 3'b010;
    return w;
  endfunction

  function automatic logic [15:0] dur_of(input state_t s);
    logic [15:0] d;
    case (s)
      S_CKE_LOW:                d = CKE_LOW_C;
      S_XPR:                    d = XPR_C;
      S_PREA0, S_PREA1:         d = RP_C;
      S_REF0, S_REF1:           d = RFC_C;
      S_EMR2, S_EMR3, S_EMR1,
      S_MR_DLLRST, S_MR:        d = MRD_C;
`ifdef DDR2_OCD_CAL_EN
      S_OCD_DEF, S_OCD_EXIT:    d = MRD_C;
`endif
      default:                  d = 16'd1;
    endcase
    return d;
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic [15:0]       cnt_r;
  logic [15:0]       cnt_hold_s;
  logic [15:0]       cnt_nxt_s;
  logic [15:0]       dll_cnt_r;
  logic [15:0]       dll_nxt_s;
  logic              enter_s;
  logic              timed_out_s;
  logic [3:0]        cmd_s;
  logic [1:0]        ba_s;
  logic [ADDR_W-1:0] addr_s;
  logic              cke_s;
  logic              done_s;

  assign state_o = state_r;

  // Next-state, interval counter and DLL-lock counter
  always_comb begin
    next_state_s = state_r;
    cnt_hold_s   = (cnt_r != 16'd0) ? (cnt_r - 16'd1) : 16'd0;
    timed_out_s  = (cnt_r <= 16'd1);
    case (state_r)
      S_CKE_LOW: begin
        // counter is 0 straight out of reset: load the CKE-low interval first
        if (cnt_r == 16'd0) begin
          cnt_hold_s = CKE_LOW_C;
        end else if (cnt_r == 16'd1) begin
          next_state_s = S_XPR;
        end else begin
          next_state_s = S_CKE_LOW;
        end
      end
      S_XPR:       next_state_s = timed_out_s ? S_PREA0     : S_XPR;
      S_PREA0:     next_state_s = timed_out_s ? S_EMR2      : S_PREA0;
      S_EMR2:      next_state_s = timed_out_s ? S_EMR3      : S_EMR2;
      S_EMR3:      next_state_s = timed_out_s ? S_EMR1      : S_EMR3;
      S_EMR1:      next_state_s = timed_out_s ? S_MR_DLLRST : S_EMR1;
      S_MR_DLLRST: next_state_s = timed_out_s ? S_PREA1     : S_MR_DLLRST;
      S_PREA1:     next_state_s = timed_out_s ? S_REF0      : S_PREA1;
      S_REF0:      next_state_s = timed_out_s ? S_REF1      : S_REF0;
      S_REF1:      next_state_s = timed_out_s ? S_MR        : S_REF1;
`ifdef DDR2_OCD_CAL_EN
      S_MR:        next_state_s = timed_out_s ? S_OCD_DEF   : S_MR;
      S_OCD_DEF:   next_state_s = timed_out_s ? S_OCD_EXIT  : S_OCD_DEF;
      S_OCD_EXIT:  next_state_s = timed_out_s ? S_DLLK      : S_OCD_EXIT;
`else
      S_MR:        next_state_s = timed_out_s ? S_DLLK      : S_MR;
`endif
      S_DLLK:      next_state_s = (dll_cnt_r >= DLLK_C) ? S_DONE : S_DLLK;
      S_DONE:      next_state_s = S_DONE;
      default:     next_state_s = S_CKE_LOW;
    endcase
    enter_s   = (next_state_s != state_r);
    cnt_nxt_s = enter_s ? dur_of(next_state_s) : cnt_hold_s;
    // DLL counter = cycles since the DLL-reset MRS, counting that cycle as 1
    if (enter_s && (next_state_s == S_MR_DLLRST)) begin
      dll_nxt_s = 16'd1;
    end else if (dll_cnt_r != 16'hFFFF) begin
      dll_nxt_s = dll_cnt_r + 16'd1;
    end else begin
      dll_nxt_s = dll_cnt_r;
    end
  end

  // Pin values for the coming cycle: a command only on the state-entry cycle, NOP otherwise
  always_comb begin
    cmd_s  = CMD_NOP;
    ba_s   = 2'd0;
    addr_s = '0;
    cke_s  = 1'b1;
    done_s = init_done;
    case (next_state_s)
      S_CKE_LOW: begin
        cmd_s = CMD_DESEL;
        cke_s = 1'b0;
      end
      S_XPR, S_DLLK: cmd_s = CMD_NOP;
      S_PREA0, S_PREA1: begin
        if (enter_s) begin
          cmd_s      = CMD_PRE;
          addr_s[10] = 1'b1;
        end else begin
          cmd_s = CMD_NOP;
        end
      end
      S_REF0, S_REF1: cmd_s = enter_s ? CMD_REF : CMD_NOP;
      S_EMR2: begin
        cmd_s = enter_s ? CMD_MRS : CMD_NOP;
        ba_s  = enter_s ? 2'd2 : 2'd0;
      end
      S_EMR3: begin
        cmd_s = enter_s ? CMD_MRS : CMD_NOP;
        ba_s  = enter_s ? 2'd3 : 2'd0;
      end
      S_EMR1: begin
        cmd_s = enter_s ? CMD_MRS : CMD_NOP;
        ba_s  = enter_s ? 2'd1 : 2'd0;
      end
      S_MR_DLLRST: begin
        cmd_s  = enter_s ? CMD_MRS : CMD_NOP;
        addr_s = enter_s ? mr_word(1'b1) : '0;
      end
      S_MR: begin
        cmd_s  = enter_s ? CMD_MRS : CMD_NOP;
        addr_s = enter_s ? mr_word(1'b0) : '0;
      end
`ifdef DDR2_OCD_CAL_EN
      S_OCD_DEF: begin
        if (enter_s) begin
          cmd_s       = CMD_MRS;
          ba_s        = 2'd1;
          addr_s[9:7] = 3'b111;
        end else begin
          cmd_s = CMD_NOP;
        end
      end
      S_OCD_EXIT: begin
        cmd_s = enter_s ? CMD_MRS : CMD_NOP;
        ba_s  = enter_s ? 2'd1 : 2'd0;
      end
`endif
      S_DONE: begin
        cmd_s  = CMD_DESEL;
        done_s = 1'b1;
      end
      default: begin
        cmd_s = CMD_DESEL;
        cke_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_CKE_LOW;
      cnt_r     <= 16'd0;
      dll_cnt_r <= 16'd0;
      cke       <= 1'b0;
      {cs_n, ras_n, cas_n, we_n} <= CMD_DESEL;
      ba        <= 2'd0;
      addr      <= '0;
      odt       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= cnt_nxt_s;
      dll_cnt_r <= dll_nxt_s;
      cke       <= cke_s;
      {cs_n, ras_n, cas_n, we_n} <= cmd_s;
      ba        <= ba_s;
      addr      <= addr_s;
      odt       <= 1'b0;
      init_done <= done_s;
    end
  end

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Table-driven bench for ddr2_init_seq: decodes the command bus and checks order, gaps and MR values.
module tb_ddr2_init_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cke, cs_n, ras_n, cas_n, we_n, odt, init_done;
  logic [1:0]  ba;
  logic [13:0] addr;
  logic [3:0]  state_o;
  logic        cke_b, cs_n_b, ras_n_b, cas_n_b, we_n_b, odt_b, init_done_b;
  logic [1:0]  ba_b;
  logic [13:0] addr_b;
  logic [3:0]  state_o_b;

  always #5 clk = ~clk;

  ddr2_init_seq u_dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .odt(odt), .init_done(init_done), .state_o(state_o)
  );

  ddr2_init_seq #(.CAS_LATENCY(4), .WRITE_RECOVERY(4)) u_dut_cl4 (
    .clk(clk), .rst(rst), .cke(cke_b), .cs_n(cs_n_b), .ras_n(ras_n_b), .cas_n(cas_n_b),
    .we_n(we_n_b), .ba(ba_b), .addr(addr_b), .odt(odt_b), .init_done(init_done_b), .state_o(state_o_b)
  );

  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_NOP = 4'b0111;

`ifdef DDR2_OCD_CAL_EN
  localparam int N_EXP = 11;
`else
  localparam int N_EXP = 9;
`endif

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [13:0] addr;
    logic [13:0] addr_cl4;
    int          gap;
  } exp_rec_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [13:0] addr;
    logic [13:0] addr_cl4;
    int          cyc;
  } evt_t;

  exp_rec_t exp_tbl[N_EXP];
  evt_t     got_q[$];
  int       n_checks = 0;
  int       n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs from rst release; optionally returns right after the first REF is seen.
  task automatic capture(input bit stop_after_ref, output bit hit_ref);
    int         low_cnt, rise_cyc, done_cyc, gap;
    bit         done_seen, odt_bad;
    logic [3:0] cmd;
    low_cnt = 0; rise_cyc = -1; done_cyc = -1; hit_ref = 1'b0; done_seen = 1'b0; odt_bad = 1'b0;
    got_q.delete();
    for (int cyc = 1; cyc <= 3000 && !done_seen; cyc++) begin
      @(negedge clk);
      cmd = {cs_n, ras_n, cas_n, we_n};
      if (odt !== 1'b0) odt_bad = 1'b1;
      if (rise_cyc < 0) begin
        if (cke === 1'b1) rise_cyc = cyc;
        else low_cnt++;
      end
      if (cs_n === 1'b0 && cmd !== C_NOP)
        got_q.push_back('{cmd: cmd, ba: ba, addr: addr, addr_cl4: addr_b, cyc: cyc});
      if (stop_after_ref && cs_n === 1'b0 && cmd === C_REF) begin
        hit_ref = 1'b1;
        return;
      end
      if (init_done === 1'b1) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
    chk("cke_low_cycles", low_cnt, 32'd100);
    chk("init_done_seen", done_seen, 32'd1);
    chk("odt_low_during_init", odt_bad, 32'd0);
    chk("cmd_count", got_q.size(), N_EXP);
    for (int i = 0; i < N_EXP && i < got_q.size(); i++) begin
      gap = (i == 0) ? (got_q[0].cyc - rise_cyc) : (got_q[i].cyc - got_q[i-1].cyc);
      chk($sformatf("cmd%0d_code", i), got_q[i].cmd, exp_tbl[i].cmd);
      chk($sformatf("cmd%0d_gap", i), gap, exp_tbl[i].gap);
      if (exp_tbl[i].cmd == C_PRE) begin
        chk($sformatf("cmd%0d_a10", i), got_q[i].addr[10], 32'd1);
      end else if (exp_tbl[i].cmd == C_MRS) begin
        chk($sformatf("cmd%0d_ba", i), got_q[i].ba, exp_tbl[i].ba);
        chk($sformatf("cmd%0d_addr", i), got_q[i].addr, exp_tbl[i].addr);
        chk($sformatf("cmd%0d_addr_cl4", i), got_q[i].addr_cl4, exp_tbl[i].addr_cl4);
      end
    end
    if (got_q.size() > 4) begin
      gap = done_cyc - got_q[4].cyc;
      chk("dll_wait_200", (gap >= 200) && (gap <= 201), 32'd1);
    end
  endtask

  initial begin
    bit hit;
    bit hold_bad;
    // {cmd, ba, addr (defaults), addr (CL4/WR4), gap from previous event}
    exp_tbl[0] = '{cmd: C_PRE, ba: 2'd0, addr: 14'h0400, addr_cl4: 14'h0400, gap: 20};
    exp_tbl[1] = '{cmd: C_MRS, ba: 2'd2, addr: 14'h0000, addr_cl4: 14'h0000, gap: 5};
    exp_tbl[2] = '{cmd: C_MRS, ba: 2'd3, addr: 14'h0000, addr_cl4: 14'h0000, gap: 2};
    exp_tbl[3] = '{cmd: C_MRS, ba: 2'd1, addr: 14'h0000, addr_cl4: 14'h0000, gap: 2};
    exp_tbl[4] = '{cmd: C_MRS, ba: 2'd0, addr: 14'h0B52, addr_cl4: 14'h0742, gap: 2};
    exp_tbl[5] = '{cmd: C_PRE, ba: 2'd0, addr: 14'h0400, addr_cl4: 14'h0400, gap: 2};
    exp_tbl[6] = '{cmd: C_REF, ba: 2'd0, addr: 14'h0000, addr_cl4: 14'h0000, gap: 5};
    exp_tbl[7] = '{cmd: C_REF, ba: 2'd0, addr: 14'h0000, addr_cl4: 14'h0000, gap: 26};
    exp_tbl[8] = '{cmd: C_MRS, ba: 2'd0, addr: 14'h0A52, addr_cl4: 14'h0642, gap: 26};
`ifdef DDR2_OCD_CAL_EN
    exp_tbl[9]  = '{cmd: C_MRS, ba: 2'd1, addr: 14'h0380, addr_cl4: 14'h0380, gap: 2};
    exp_tbl[10] = '{cmd: C_MRS, ba: 2'd1, addr: 14'h0000, addr_cl4: 14'h0000, gap: 2};
`endif

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pins", {cke, cs_n, ras_n, cas_n, we_n, odt, init_done}, 32'b0111100);
    chk("rst_ba", ba, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_state", state_o, 32'd0);
    rst = 1'b0;

    capture(1'b0, hit);
    hold_bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (init_done !== 1'b1 || cs_n !== 1'b1 || odt !== 1'b0 || cke !== 1'b1) hold_bad = 1'b1;
    end
    chk("done_hold", hold_bad, 32'd0);
    chk("state_done", state_o, 32'd14);

    // Restart, then hit rst in the cycle after the first REF
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    capture(1'b1, hit);
    chk("ref_reached", hit, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cke", cke, 32'd0);
    chk("midrst_done", init_done, 32'd0);
    chk("midrst_state", state_o, 32'd0);
    chk("midrst_cs_n", cs_n, 32'd1);
    rst = 1'b0;
    capture(1'b0, hit);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr2_init_seq.md
Name: ddr2_init_seq

Overview:
- Power-up initialization sequencer for a single-rank DDR2 DIMM of eight x8 devices sharing one command/address bus.
- After reset it drives the JEDEC DDR2 init command sequence on the shared CKE/CS#/RAS#/CAS#/WE#/BA/ADDR/ODT pins, then asserts init_done.
- Sits between the scheduler's command mux and the DDR_IF; the mux hands the bus to the scheduler once init_done=1.

Parameters:
- T_CKE_LOW, 100, cycles CKE held low after reset (stand-in for the 200 us spec).
- T_XPR, 20, NOP cycles after CKE rises before the first PREA.
- T_RP, 5, cycles from PREA to next command.
- T_MRD, 2, cycles from MRS/EMRS to next command.
- T_RFC, 26, cycles from REF to next command.
- T_DLLK, 200, minimum cycles from the MRS-with-DLL-reset command to init_done.
- CAS_LATENCY, 5, MR[6:4].
- WRITE_RECOVERY, 6, MR[11:9] = WRITE_RECOVERY-1.
- ADDR_W, 14, address bus width.

Ports:
- clk  in  1  controller clock (= DRAM ck)
- rst  in  1  synchronous, active-high reset
- cke  out  1  clock enable
- cs_n  out  1  chip select, active low
- ras_n  out  1  row address strobe, active low
- cas_n  out  1  column address strobe, active low
- we_n  out  1  write enable, active low
- ba  out  2  bank address
- addr  out  ADDR_W  address / mode-register value
- odt  out  1  on-die termination, held 0 throughout
- init_done  out  1  sequence complete; sticky until rst
- state_o  out  4  current FSM state, for debug

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: cke=0, cs_n=1, ras_n=1, cas_n=1, we_n=1, ba=0, addr=0, odt=0, init_done=0, state=S_CKE_LOW, counter=0.
- Command encodings as {cs_n,ras_n,cas_n,we_n}:
  - DESEL = 1xxx, driven as 1111.
  - NOP = 0111.
  - PRE = 0010, with addr[10]=1 (PREA).
  - REF = 0001.
  - MRS = 0000.
- Each command is driven for exactly one cycle. NOPs follow, so the next command appears exactly T_x cycles after the previous one.
- Down-counter: 16 bits, loaded at each state entry, advances state when it reaches 1.
- FSM states and actions:
  - S_CKE_LOW: DESEL, cke=0 for T_CKE_LOW cycles.
  - S_XPR: cke=1, NOP for T_XPR cycles.
  - S_PREA0: PREA, then wait T_RP.
  - S_EMR2: MRS with ba=2, addr=0, then wait T_MRD.
  - S_EMR3: MRS with ba=3, addr=0, then wait T_MRD.
  - S_EMR1: MRS with ba=1, addr=0 (DLL enable, full drive, Rtt off, DQS# enabled), then wait T_MRD.
  - S_MR_DLLRST: MRS with ba=0, addr = {0, WR-1 in [11:9], 1 in [8], 0 in [7], CL in [6:4], 0 in [3] (sequential), 3'b010 in [2:0] (BL4)}, then wait T_MRD. A separate DLL counter starts at this command.
  - S_PREA1: PREA, then wait T_RP.
  - S_REF0: REF, then wait T_RFC.
  - S_REF1: REF, then wait T_RFC.
  - S_MR: same MR value with addr[8]=0, then wait T_MRD.
  - S_DLLK: NOP until the DLL counter reaches T_DLLK.
  - S_DONE: init_done=1; cs_n=1, cke=1, all others held at idle; the state is terminal.
- In S_DLLK, if T_DLLK has already elapsed on entry, move to S_DONE on the next cycle.
- rst asserted in any state, including mid-command, returns to the reset values on the next edge. cke drops to 0 immediately and the sequence restarts from S_CKE_LOW.
- A parameter value of 0 is treated as 1.
- CKE must never rise before T_CKE_LOW cycles have elapsed.

Optional Feature:
- Macro: DDR2_OCD_CAL_EN.
- Defined: after S_MR, two extra states run before S_DLLK.
  - S_OCD_DEF: MRS ba=1, addr[9:7]=3'b111, then wait T_MRD.
  - S_OCD_EXIT: MRS ba=1, addr=0, then wait T_MRD.
- Not defined: S_MR goes directly to S_DLLK and the OCD states are not synthesized.

Test Plan:
- Release rst with default parameters:
  - cke=0 for 100 cycles, then cke=1.
  - First PREA appears exactly 20 cycles after cke rises, with addr[10]=1.
- Decode the command bus and log it: the order is PREA, EMR2, EMR3, EMR1, MR(addr=0x0B52), PREA, REF, REF, MR(addr=0x0A52).
  - Gaps between commands: 5, 2, 2, 2, 2, 5, 26, 26 cycles.
- Count cycles from the MR_DLLRST command to the init_done rising edge: the count is at least 200. init_done stays high for 1000 further cycles with cs_n=1 and odt=0 throughout.
- Assert rst for 1 cycle in the cycle after the first REF:
  - Next cycle: cke=0, init_done=0, state_o=S_CKE_LOW.
  - The full sequence then repeats identically.
- Build with CAS_LATENCY=4 and WRITE_RECOVERY=4: MR_DLLRST addr=0x0742, final MR addr=0x0642.
- Build with DDR2_OCD_CAL_EN: after the final MR, EMR1 addr=0x0380 then EMR1 addr=0x0000 appear, 2 cycles apart. Without the macro, neither command appears.
